// File: rtl/ghr_ckpt_ctrl.sv
// Global branch history controller: speculative/architectural GHR with a circular
// per-branch checkpoint buffer. Optional GHR_STATS_EN adds mispredict/flush counters.
module ghr_ckpt_ctrl #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic             pred_taken,
    output logic             pred_ready,
    output logic [TAG_W-1:0] pred_tag,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_mispredict,
    input  logic             res_taken,
    input  logic             retire_valid,
    input  logic             retire_taken,
    input  logic             flush,
`ifdef GHR_STATS_EN
    output logic [31:0]      mispredict_cnt,
    output logic [31:0]      flush_cnt,
`endif
    output logic [W-1:0]     spec_hist,
    output logic [W-1:0]     arch_hist
);

    localparam int PW = TAG_W + 1;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [PW-1:0]    head_r, tail_r;
    logic [PW-1:0]    head_nxt_s, tail_nxt_s;
    logic [PW-1:0]    count_s, res_pos_s;
    logic [TAG_W-1:0] res_off_s;
    logic [W-1:0]     spec_hist_r, arch_hist_r;
    logic [W-1:0]     spec_nxt_s, arch_nxt_s;
    logic [W-1:0]     ckpt_r [DEPTH];
    logic             full_s, res_in_flight_s, mis_s, retire_s, accept_s, ready_s;

    // Offset of a tag from the oldest in-flight entry, modulo the buffer depth.
    function automatic logic [TAG_W-1:0] tag_offset(input logic [TAG_W-1:0] tag,
                                                    input logic [TAG_W-1:0] head_idx);
        return tag - head_idx;
    endfunction

    assign count_s         = tail_r - head_r;
    assign full_s          = (count_s == PW'(DEPTH));
    assign res_off_s       = tag_offset(res_tag, head_r[TAG_W-1:0]);
    assign res_in_flight_s = ({1'b0, res_off_s} < count_s);
    assign res_pos_s       = head_r + {1'b0, res_off_s};
    assign mis_s           = res_valid & res_mispredict & res_in_flight_s;
    assign retire_s        = retire_valid & (count_s != {PW{1'b0}});
    assign accept_s        = pred_valid & ready_s & ~flush & ~mis_s;

    assign pred_ready = ready_s;
    assign pred_tag   = tail_r[TAG_W-1:0];
    assign spec_hist  = spec_hist_r;
    assign arch_hist  = arch_hist_r;

    // Readiness is a function of registered state only (no retire bypass).
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            RUN:     ready_s = ~full_s;
            RECOVER: ready_s = 1'b0;
            default: ready_s = 1'b0;
        endcase
    end

    // Retire path: always processed, feeds the flush restore value.
    always_comb begin
        arch_nxt_s = arch_hist_r;
        head_nxt_s = head_r;
        if (retire_s) begin
            arch_nxt_s = {arch_hist_r[W-2:0], retire_taken};
            head_nxt_s = head_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            arch_nxt_s = arch_hist_r;
            head_nxt_s = head_r;
        end
    end

    // Speculative path and FSM: flush > mispredict > accept.
    always_comb begin
        spec_nxt_s  = spec_hist_r;
        tail_nxt_s  = tail_r;
        state_nxt_s = RUN;
        if (flush) begin
            spec_nxt_s  = arch_nxt_s;
            tail_nxt_s  = head_nxt_s;
            state_nxt_s = RECOVER;
        end else if (mis_s) begin
            spec_nxt_s  = {ckpt_r[res_tag][W-2:0], res_taken};
            tail_nxt_s  = res_pos_s + {{(PW-1){1'b0}}, 1'b1};
            state_nxt_s = RECOVER;
        end else if (accept_s) begin
            spec_nxt_s  = {spec_hist_r[W-2:0], pred_taken};
            tail_nxt_s  = tail_r + {{(PW-1){1'b0}}, 1'b1};
            state_nxt_s = RUN;
        end else begin
            spec_nxt_s  = spec_hist_r;
            tail_nxt_s  = tail_r;
            state_nxt_s = RUN;
        end
    end

    // State, pointer and history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= RUN;
            head_r      <= {PW{1'b0}};
            tail_r      <= {PW{1'b0}};
            spec_hist_r <= {W{1'b0}};
            arch_hist_r <= {W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            spec_hist_r <= spec_nxt_s;
            arch_hist_r <= arch_nxt_s;
        end
    end

    // Checkpoint buffer captures pre-shift history for each accepted branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ckpt_r[i] <= {W{1'b0}};
            end
        end else if (accept_s) begin
            ckpt_r[tail_r[TAG_W-1:0]] <= spec_hist_r;
        end
    end

`ifdef GHR_STATS_EN
    logic [31:0] mis_cnt_r, flush_cnt_r;

    // Event counters; a mispredict shadowed by a flush is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            mis_cnt_r   <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (mis_s && !flush) begin
                mis_cnt_r <= mis_cnt_r + 32'd1;
            end
            if (flush) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign mispredict_cnt = mis_cnt_r;
    assign flush_cnt      = flush_cnt_r;
`endif

endmodule
